// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE-array feeder blocks: FSM state
// encoding, default element width and the lane packing helper.
package pe_pkg;

    localparam int PE_DATA_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } skew_state_e;

    // Bit offset of lane 'lane' inside a packed row of 'width'-bit elements.
    function automatic int lane_slice(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/pe_skew_buffer.sv
// Tile row buffer: one row-wide write port and one read port per lane, each
// lane reading its own element from its own row index. Memory is not reset.
module pe_skew_buffer
    import pe_pkg::*;
#(
    parameter int ARRAY_COLS = 8,
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int MAX_DEPTH  = 8,
    parameter int ADDR_WIDTH = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1
) (
    input  logic                             clk,
    input  logic                             i_wr_en,
    input  logic [ADDR_WIDTH-1:0]            i_wr_addr,
    input  logic [ARRAY_COLS*DATA_WIDTH-1:0] i_wr_data,
    input  logic [ARRAY_COLS*ADDR_WIDTH-1:0] i_rd_addr,
    output logic [ARRAY_COLS*DATA_WIDTH-1:0] o_rd_data
);

    localparam int ROW_W = ARRAY_COLS * DATA_WIDTH;

    logic [ROW_W-1:0]      r_mem [MAX_DEPTH];
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ROW_W-1:0]      w_row;

    // Row write port.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Lane read ports; write-through so a one-row tile streams the cycle after its write.
    always_comb begin
        o_rd_data = '0;
        w_addr    = '0;
        w_row     = '0;
        for (int l = 0; l < ARRAY_COLS; l++) begin
            w_addr = i_rd_addr[l*ADDR_WIDTH +: ADDR_WIDTH];
            if (i_wr_en && (w_addr == i_wr_addr)) begin
                w_row = i_wr_data;
            end else if (int'(w_addr) < MAX_DEPTH) begin
                w_row = r_mem[w_addr];
            end else begin
                w_row = '0;
            end
            o_rd_data[lane_slice(l, DATA_WIDTH) +: DATA_WIDTH] =
                w_row[lane_slice(l, DATA_WIDTH) +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/pe_skew_feeder.sv
// Systolic west-edge feeder: buffers a tile of rows, then streams it with
// diagonal per-lane skew. Optional lane_first output with PE_SKEW_FIRST_FLAG_EN.
module pe_skew_feeder
    import pe_pkg::*;
#(
    parameter int ARRAY_COLS  = 8,
    parameter int DATA_WIDTH  = PE_DATA_WIDTH,
    parameter int MAX_DEPTH   = 8,
    parameter int DEPTH_WIDTH = $clog2(MAX_DEPTH + 1),
    parameter int STEP_WIDTH  = $clog2(MAX_DEPTH + ARRAY_COLS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [DEPTH_WIDTH-1:0]           cfg_depth,
    input  logic                             row_valid,
    output logic                             row_ready,
    input  logic [ARRAY_COLS*DATA_WIDTH-1:0] row_data,
    input  logic                             out_stall,
    output logic [ARRAY_COLS*DATA_WIDTH-1:0] lane_data,
    output logic [ARRAY_COLS-1:0]            lane_valid,
    output logic                             busy,
    output logic                             done
`ifdef PE_SKEW_FIRST_FLAG_EN
    ,
    output logic [ARRAY_COLS-1:0]            lane_first
`endif
);

    localparam int CW    = ((DEPTH_WIDTH > STEP_WIDTH) ? DEPTH_WIDTH : STEP_WIDTH) + 1;
    localparam int AW    = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam int ROW_W = ARRAY_COLS * DATA_WIDTH;

    skew_state_e            r_state;
    skew_state_e            w_state_nxt;
    logic [DEPTH_WIDTH-1:0] r_depth;
    logic [DEPTH_WIDTH-1:0] w_depth_nxt;
    logic [DEPTH_WIDTH-1:0] w_depth_clamp;
    logic [DEPTH_WIDTH-1:0] r_wr_ptr;
    logic [DEPTH_WIDTH-1:0] w_wr_ptr_nxt;
    logic [STEP_WIDTH-1:0]  r_step;
    logic [STEP_WIDTH-1:0]  w_step_nxt;
    logic [CW-1:0]          w_step_inc;
    logic [CW-1:0]          w_stream_len;
    logic                   w_wr_en;

    logic [ARRAY_COLS*AW-1:0] w_rd_addr;
    logic [ROW_W-1:0]         w_rd_data;
    logic [ROW_W-1:0]         w_lane_data_nxt;
    logic [ARRAY_COLS-1:0]    w_lane_valid_nxt;
    logic [ROW_W-1:0]         r_lane_data;
    logic [ARRAY_COLS-1:0]    r_lane_valid;
    logic                     r_busy;
    logic                     r_row_ready;
    logic                     r_done;
`ifdef PE_SKEW_FIRST_FLAG_EN
    logic [ARRAY_COLS-1:0]    w_lane_first_nxt;
    logic [ARRAY_COLS-1:0]    r_lane_first;
`endif

    pe_skew_buffer #(
        .ARRAY_COLS (ARRAY_COLS),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_DEPTH  (MAX_DEPTH),
        .ADDR_WIDTH (AW)
    ) u_buf (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (AW'(r_wr_ptr)),
        .i_wr_data (row_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // Next-state, write-pointer and step-counter logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_depth_nxt   = r_depth;
        w_wr_ptr_nxt  = r_wr_ptr;
        w_step_nxt    = r_step;
        w_wr_en       = 1'b0;
        w_step_inc    = CW'(r_step) + CW'(1);
        w_stream_len  = CW'(r_depth) + CW'(ARRAY_COLS) - CW'(1);
        w_depth_clamp = (cfg_depth > DEPTH_WIDTH'(MAX_DEPTH)) ? DEPTH_WIDTH'(MAX_DEPTH) : cfg_depth;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_depth_nxt  = w_depth_clamp;
                    w_wr_ptr_nxt = '0;
                    w_step_nxt   = '0;
                    w_state_nxt  = (w_depth_clamp == '0) ? DONE : LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOAD: begin
                if (row_valid) begin
                    w_wr_en      = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + DEPTH_WIDTH'(1);
                    if (w_wr_ptr_nxt == r_depth) begin
                        w_state_nxt = STREAM;
                        w_step_nxt  = '0;
                    end else begin
                        w_state_nxt = LOAD;
                    end
                end else begin
                    w_state_nxt = LOAD;
                end
            end
            STREAM: begin
                if (!out_stall) begin
                    if (w_step_inc == w_stream_len) begin
                        w_state_nxt = DONE;
                        w_step_nxt  = '0;
                    end else begin
                        w_step_nxt  = w_step_inc[STEP_WIDTH-1:0];
                    end
                end else begin
                    w_state_nxt = STREAM;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Lane l reads buffer row (step - l) for the step about to be presented.
    always_comb begin
        w_rd_addr = '0;
        for (int l = 0; l < ARRAY_COLS; l++) begin
            w_rd_addr[l*AW +: AW] = AW'(CW'(w_step_nxt) - CW'(l));
        end
    end

    // Diagonal valid window and lane data for the next cycle's registered outputs.
    always_comb begin
        w_lane_valid_nxt = '0;
        w_lane_data_nxt  = '0;
`ifdef PE_SKEW_FIRST_FLAG_EN
        w_lane_first_nxt = '0;
`endif
        for (int l = 0; l < ARRAY_COLS; l++) begin
            if ((w_state_nxt == STREAM) &&
                (CW'(w_step_nxt) >= CW'(l)) &&
                (CW'(w_step_nxt) < (CW'(w_depth_nxt) + CW'(l)))) begin
                w_lane_valid_nxt[l] = 1'b1;
                w_lane_data_nxt[lane_slice(l, DATA_WIDTH) +: DATA_WIDTH] =
                    w_rd_data[lane_slice(l, DATA_WIDTH) +: DATA_WIDTH];
`ifdef PE_SKEW_FIRST_FLAG_EN
                w_lane_first_nxt[l] = (CW'(w_step_nxt) == CW'(l));
`endif
            end else begin
                w_lane_valid_nxt[l] = 1'b0;
            end
        end
    end

    // State and registered outputs; reset aborts any tile in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_depth      <= '0;
            r_wr_ptr     <= '0;
            r_step       <= '0;
            r_lane_data  <= '0;
            r_lane_valid <= '0;
            r_busy       <= 1'b0;
            r_row_ready  <= 1'b0;
            r_done       <= 1'b0;
`ifdef PE_SKEW_FIRST_FLAG_EN
            r_lane_first <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_depth      <= w_depth_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_step       <= w_step_nxt;
            r_lane_data  <= w_lane_data_nxt;
            r_lane_valid <= w_lane_valid_nxt;
            r_busy       <= (w_state_nxt != IDLE);
            r_row_ready  <= (w_state_nxt == LOAD);
            r_done       <= (w_state_nxt == DONE);
`ifdef PE_SKEW_FIRST_FLAG_EN
            r_lane_first <= w_lane_first_nxt;
`endif
        end
    end

    assign lane_data  = r_lane_data;
    assign lane_valid = r_lane_valid;
    assign busy       = r_busy;
    assign row_ready  = r_row_ready;
    assign done       = r_done;
`ifdef PE_SKEW_FIRST_FLAG_EN
    assign lane_first = r_lane_first;
`endif

endmodule

// File: tb/tb_pe_skew_feeder.sv
// Randomized bench for pe_skew_feeder (4 lanes, 8-row buffer) against a
// tile-level model: lane l shows row t-l at stream step t.
module tb_pe_skew_feeder;

    localparam int AC = 4;
    localparam int DW = 4;
    localparam int MD = 8;
    localparam int RW = AC * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    cfg_depth;
    logic          row_valid;
    logic          row_ready;
    logic [RW-1:0] row_data;
    logic          out_stall;
    logic [RW-1:0] lane_data;
    logic [AC-1:0] lane_valid;
    logic          busy;
    logic          done;
`ifdef PE_SKEW_FIRST_FLAG_EN
    logic [AC-1:0] lane_first;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pe_skew_feeder #(
        .ARRAY_COLS (AC),
        .DATA_WIDTH (DW),
        .MAX_DEPTH  (MD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_depth  (cfg_depth),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_data   (row_data),
        .out_stall  (out_stall),
        .lane_data  (lane_data),
        .lane_valid (lane_valid),
        .busy       (busy),
`ifdef PE_SKEW_FIRST_FLAG_EN
        .lane_first (lane_first),
`endif
        .done       (done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_valid"}, 64'(lane_valid), 64'd0);
        check_eq({tag, "_data"},  64'(lane_data),  64'd0);
        check_eq({tag, "_busy"},  64'(busy),       64'd0);
        check_eq({tag, "_ready"}, 64'(row_ready),  64'd0);
        check_eq({tag, "_done"},  64'(done),       64'd0);
`ifdef PE_SKEW_FIRST_FLAG_EN
        check_eq({tag, "_first"}, 64'(lane_first), 64'd0);
`endif
    endtask

    // One tile: start, load rows (with gaps), stream (with stalls), done.
    task automatic run_tile(input int cfg, input bit pattern, input int stall_at,
                            input int stall_len, input bit rnd_stall, input int abort_at);
        logic [RW-1:0] rows [MD];
        logic [AC-1:0] exp_v;
        logic [AC-1:0] exp_f;
        logic [RW-1:0] exp_d;
        int eff, r, t, guard, stalls_done;
        bit hs, stall;
        eff = (cfg > MD) ? MD : cfg;
        for (int i = 0; i < MD; i++) begin
            for (int c = 0; c < AC; c++) begin
                rows[i][c*DW +: DW] = pattern ? DW'((4*i + c) % 16) : DW'($urandom);
            end
        end
        check_eq("idle_busy",  64'(busy),      64'd0);
        check_eq("idle_ready", 64'(row_ready), 64'd0);
        start = 1'b1;
        cfg_depth = 4'(cfg);
        @(posedge clk); #1;
        start = 1'b0;
        if (eff == 0) begin
            check_eq("d0_done",  64'(done),       64'd1);
            check_eq("d0_busy",  64'(busy),       64'd1);
            check_eq("d0_ready", 64'(row_ready),  64'd0);
            check_eq("d0_valid", 64'(lane_valid), 64'd0);
            @(posedge clk); #1;
            check_quiet("d0_after");
            return;
        end
        r = 0;
        guard = 0;
        while (r < eff && guard < 200) begin
            check_eq("load_ready", 64'(row_ready),  64'd1);
            check_eq("load_busy",  64'(busy),       64'd1);
            check_eq("load_valid", 64'(lane_valid), 64'd0);
            check_eq("load_done",  64'(done),       64'd0);
            hs = ($urandom_range(0, 3) != 0);
            row_valid = hs;
            row_data  = hs ? rows[r] : RW'($urandom);
            out_stall = 1'($urandom);
            start     = 1'($urandom);
            cfg_depth = 4'($urandom);
            @(posedge clk); #1;
            if (hs) r++;
            guard++;
        end
        check_eq("load_rows", 64'(r), 64'(eff));
        t = 0;
        guard = 0;
        stalls_done = 0;
        while (t < eff + AC - 1 && guard < 200) begin
            exp_v = '0;
            exp_d = '0;
            exp_f = '0;
            for (int l = 0; l < AC; l++) begin
                if (t >= l && t < eff + l) begin
                    exp_v[l] = 1'b1;
                    exp_d[l*DW +: DW] = rows[t-l][l*DW +: DW];
                    exp_f[l] = (t == l);
                end
            end
            check_eq("lane_valid", 64'(lane_valid), 64'(exp_v));
            check_eq("lane_data",  64'(lane_data),  64'(exp_d));
`ifdef PE_SKEW_FIRST_FLAG_EN
            check_eq("lane_first", 64'(lane_first), 64'(exp_f));
`endif
            check_eq("strm_busy",  64'(busy),      64'd1);
            check_eq("strm_ready", 64'(row_ready), 64'd0);
            check_eq("strm_done",  64'(done),      64'd0);
            if (t == abort_at) begin
                start = 1'b0;
                row_valid = 1'b0;
                out_stall = 1'b0;
                rst = 1'b0;
                #2;
                check_quiet("abort");
                @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                check_quiet("post_abort");
                return;
            end
            stall = (rnd_stall && $urandom_range(0, 3) == 0) ||
                    (t == stall_at && stalls_done < stall_len);
            if (t == stall_at && stall) stalls_done++;
            out_stall = stall;
            row_valid = 1'($urandom);
            row_data  = RW'($urandom);
            start     = 1'($urandom);
            cfg_depth = 4'($urandom);
            @(posedge clk); #1;
            if (!stall) t++;
            guard++;
        end
        out_stall = 1'b0;
        row_valid = 1'b0;
        start = 1'b0;
        check_eq("strm_steps", 64'(t), 64'(eff + AC - 1));
        check_eq("fin_done",  64'(done),       64'd1);
        check_eq("fin_busy",  64'(busy),       64'd1);
        check_eq("fin_valid", 64'(lane_valid), 64'd0);
        check_eq("fin_data",  64'(lane_data),  64'd0);
        check_eq("fin_ready", 64'(row_ready),  64'd0);
        @(posedge clk); #1;
        check_quiet("after_done");
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        cfg_depth = '0;
        row_valid = 1'b0;
        row_data = '0;
        out_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b1;
        @(posedge clk); #1;
        check_quiet("released");
        run_tile(4, 1'b1, -1, 0, 1'b0, -1);
        run_tile(2, 1'b1, -1, 0, 1'b0, -1);
        run_tile(4, 1'b1, 2, 3, 1'b0, -1);
        run_tile(0, 1'b1, -1, 0, 1'b0, -1);
        run_tile(9, 1'b1, -1, 0, 1'b0, -1);
        run_tile(1, 1'b0, -1, 0, 1'b0, -1);
        run_tile(4, 1'b1, -1, 0, 1'b0, 3);
        run_tile(4, 1'b1, -1, 0, 1'b0, -1);
        for (int k = 0; k < 40; k++) begin
            run_tile($urandom_range(0, 10), 1'b0, $urandom_range(0, 12),
                     $urandom_range(0, 3), 1'($urandom), -1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
